// File: rtl/wb_slave_pkg.sv
// Shared types and constants for the Wishbone classic responder.
// Bus bundles, FSM state encoding and the forced-response data word.
package wb_slave_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
  } wb_m2s_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] data;
  } wb_s2m_t;

  typedef enum logic [1:0] {
    WBS_ST_IDLE  = 2'd0,
    WBS_ST_WAIT  = 2'd1,
    WBS_ST_ACK   = 2'd2,
    WBS_ST_DRAIN = 2'd3
  } wbs_state_e;

  localparam logic [31:0] WBS_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb_slave_timeout_cnt.sv
// Wait-cycle counter for the responder's optional timeout.
// Flags expiry on the cycle in which the count would reach limit.
module wb_timeout_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        o_expired
);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  // compare one ahead so the limit-th waiting cycle triggers
  assign o_expired = enable &&
    (({1'b0, cnt} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/wb_slave.sv
// Wishbone classic single-transfer responder to a native req/valid port.
// Optional response timeout under macro WB_SLAVE_TIMEOUT_EN.
module wb_slave
  import wb_slave_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  wb_m2s_t     i_wb,
  output wb_s2m_t     o_wb,
  output logic        o_en,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic [3:0]  o_strobe,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  output logic        o_timeout
);

  wbs_state_e  state;
  wbs_state_e  state_nx;
  logic        ack_nx;
  logic [31:0] rdata_nx;
  logic        en_nx;
  logic        accept;
  logic        to_nx;
  logic        expired;

`ifdef WB_SLAVE_TIMEOUT_EN
  logic clr;
  logic cnt_en;

  assign cnt_en = (state == WBS_ST_WAIT) ||
                  (state == WBS_ST_DRAIN);
  assign clr = (state_nx != state) &&
               ((state_nx == WBS_ST_WAIT) ||
                (state_nx == WBS_ST_DRAIN));

  wb_timeout_cnt u_cnt (
    .clk       (i_clk),
    .rst       (i_rst),
    .clear     (clr),
    .enable    (cnt_en),
    .limit     (TIMEOUT_CYCLES),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_timeout <= 1'b0;
    else       o_timeout <= to_nx;
  end
`else
  logic unused_limit;

  assign unused_limit = ^TIMEOUT_CYCLES;
  assign expired      = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= WBS_ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ack_nx   = 1'b0;
    rdata_nx = o_wb.data;
    en_nx    = 1'b0;
    accept   = 1'b0;
    to_nx    = 1'b0;
    unique case (state)
      WBS_ST_IDLE: begin
        if (i_wb.cyc && i_wb.stb) begin
          accept   = 1'b1;
          en_nx    = 1'b1;
          state_nx = WBS_ST_WAIT;
        end
      end
      WBS_ST_WAIT: begin
        // abort outranks a coincident completion
        if (!i_wb.cyc) begin
          state_nx = i_valid ? WBS_ST_IDLE
                             : WBS_ST_DRAIN;
        end else if (i_valid) begin
          ack_nx   = 1'b1;
          rdata_nx = o_we ? 32'h0 : i_data;
          state_nx = WBS_ST_ACK;
        end else if (expired) begin
          ack_nx   = 1'b1;
          rdata_nx = WBS_TIMEOUT_DATA;
          to_nx    = 1'b1;
          state_nx = WBS_ST_ACK;
        end
      end
      WBS_ST_ACK: begin
        // a forced ack still owes the native side a completion
        state_nx = o_timeout ? WBS_ST_DRAIN
                             : WBS_ST_IDLE;
      end
      WBS_ST_DRAIN: begin
        if (i_valid || expired) begin
          state_nx = WBS_ST_IDLE;
        end
      end
      default: state_nx = WBS_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb     <= '0;
      o_en     <= 1'b0;
      o_we     <= 1'b0;
      o_addr   <= '0;
      o_data   <= '0;
      o_strobe <= '0;
    end else begin
      o_wb.ack  <= ack_nx;
      o_wb.data <= rdata_nx;
      o_en      <= en_nx;
      if (accept) begin
        o_we     <= i_wb.we;
        o_addr   <= i_wb.addr;
        o_data   <= i_wb.data;
        o_strobe <= i_wb.sel;
      end
    end
  end

endmodule
